// File: rtl/inference_result_streamer_pkg.sv
// Shared types and constants for the inference result streamer.
package tinyml_stream_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_DATA, S_IDX, S_CSUM} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         FRAME_OVERHEAD = 3;
endpackage

// File: rtl/inference_result_streamer_if.sv
// Byte stream link towards the host (UART TX or debug FIFO).
interface inference_result_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/inference_result_streamer_argmax.sv
// Sequential signed argmax: one lane per cycle, strict compare so ties keep the lowest index.
module argmax_scanner #(
    parameter int N     = 10,
    parameter int W     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic signed [W-1:0]  i_first,
    input  logic signed [W-1:0]  i_vec [0:N-1],
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_done
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic                r_active;
    logic [IDX_W-1:0]    r_k;
    logic [IDX_W-1:0]    r_idx;
    logic signed [W-1:0] r_max;

    logic                w_gt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic signed [W-1:0] w_max_nxt;

    // Lane 0 arrives with the start pulse because the caller's capture register is not loaded yet
    assign w_gt      = i_vec[r_k] > r_max;
    assign w_idx_nxt = w_gt ? r_k : r_idx;
    assign w_max_nxt = w_gt ? i_vec[r_k] : r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_k      <= '0;
            r_idx    <= '0;
            r_max    <= '0;
            o_idx    <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_active <= 1'b1;
                r_max    <= i_first;
                r_idx    <= '0;
                r_k      <= IDX_W'(1);
            end else if (r_active) begin
                r_max <= w_max_nxt;
                r_idx <= w_idx_nxt;
                if (r_k == LAST) begin
                    r_active <= 1'b0;
                    o_idx    <= w_idx_nxt;
                    o_done   <= 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/inference_result_streamer.sv
// Captures accelerator results, finds the argmax and streams a framed packet:
// SYNC, OUT_N raw lanes, argmax index, XOR checksum.
module inference_result_streamer
    import tinyml_stream_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         OUT_N      = 10,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         IDX_W      = $clog2(OUT_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_i,
    input  logic signed [DATA_WIDTH-1:0] y_i [0:OUT_N-1],
    input  logic                         clear_i,
    inference_result_streamer_if.master  tx,
    output logic [IDX_W-1:0]             argmax_o,
    output logic                         argmax_valid_o,
    output logic                         busy_o,
    output logic                         overrun_o
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_N - 1);

    state_t                       r_state;
    logic signed [DATA_WIDTH-1:0] r_cap [0:OUT_N-1];
    logic [IDX_W-1:0]             r_j;
    logic [7:0]                   r_csum;
    logic [7:0]                   r_tx_data;
    logic                         r_tx_valid;
    logic                         r_overrun;

    logic                         w_hs;
    logic                         w_start;
    logic                         w_scan_done;
    logic [7:0]                   w_idx_byte;

    assign w_hs       = r_tx_valid && tx.tx_ready;
    assign w_start    = (r_state == S_IDLE) && done_i;
    assign w_idx_byte = 8'(argmax_o);

    assign tx.tx_data     = r_tx_data;
    assign tx.tx_valid    = r_tx_valid;
    assign busy_o         = (r_state != S_IDLE);
    assign overrun_o      = r_overrun;
    assign argmax_valid_o = w_scan_done;

    argmax_scanner #(.N(OUT_N), .W(DATA_WIDTH), .IDX_W(IDX_W)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_first (y_i[0]),
        .i_vec   (r_cap),
        .o_idx   (argmax_o),
        .o_done  (w_scan_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_j        <= '0;
            r_csum     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            for (int i = 0; i < OUT_N; i++) r_cap[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (done_i) begin
                    for (int i = 0; i < OUT_N; i++) r_cap[i] <= y_i[i];
                    r_state <= S_SCAN;
                end
                S_SCAN: if (w_scan_done) begin
                    r_state    <= S_HDR;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= SYNC_BYTE;
                    r_csum     <= SYNC_BYTE;
                end
                S_HDR: if (w_hs) begin
                    r_state   <= S_DATA;
                    r_j       <= '0;
                    r_tx_data <= r_cap[0];
                end
                S_DATA: if (w_hs) begin
                    r_csum <= r_csum ^ r_cap[r_j];
                    if (r_j == LAST) begin
                        r_state   <= S_IDX;
                        r_tx_data <= w_idx_byte;
                    end else begin
                        r_j       <= r_j + 1'b1;
                        r_tx_data <= r_cap[r_j + 1'b1];
                    end
                end
                S_IDX: if (w_hs) begin
                    r_state   <= S_CSUM;
                    r_csum    <= r_csum ^ w_idx_byte;
                    r_tx_data <= r_csum ^ w_idx_byte;
                end
                S_CSUM: if (w_hs) begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A done pulse while busy is dropped; a new drop beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_overrun <= 1'b0;
        else if (done_i && busy_o) r_overrun <= 1'b1;
        else if (clear_i)          r_overrun <= 1'b0;
    end
endmodule

// File: tb/tb_inference_result_streamer.sv
// Directed bench for inference_result_streamer: framing, argmax, backpressure, overrun, reset.
module tb_inference_result_streamer;
    import tinyml_stream_pkg::*;

    localparam int OUT_N = 10;
    localparam int NB    = OUT_N + FRAME_OVERHEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_i = 1'b0;
    logic clear_i = 1'b0;
    logic signed [7:0] y [0:OUT_N-1];
    logic [3:0] argmax;
    logic argmax_valid, busy, overrun;

    inference_result_streamer_if bus();

    inference_result_streamer #(.OUT_N(OUT_N)) dut (
        .clk            (clk),
        .rst            (rst),
        .done_i         (done_i),
        .y_i            (y),
        .clear_i        (clear_i),
        .tx             (bus),
        .argmax_o       (argmax),
        .argmax_valid_o (argmax_valid),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] got  [0:31];
    logic [7:0] expf [0:NB-1];
    int got_n, stab_err;
    logic [7:0] V1 [0:OUT_N-1];
    logic [7:0] VT [0:OUT_N-1];
    logic [7:0] VN [0:OUT_N-1];

    task automatic load_y(input logic [7:0] v [0:OUT_N-1]);
        for (int i = 0; i < OUT_N; i++) y[i] = v[i];
    endtask

    task automatic start(input logic [7:0] v [0:OUT_N-1]);
        load_y(v);
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] v [0:OUT_N-1], input logic [7:0] idx);
        logic [7:0] cs;
        expf[0] = 8'hA5;
        cs = 8'hA5;
        for (int i = 0; i < OUT_N; i++) begin
            expf[i+1] = v[i];
            cs = cs ^ v[i];
        end
        expf[OUT_N+1] = idx;
        expf[OUT_N+2] = cs ^ idx;
    endtask

    function automatic int first_bad();
        for (int i = 0; i < NB; i++) if (got[i] !== expf[i]) return i;
        if (got_n != NB) return NB;
        return -1;
    endfunction

    // Accept bytes with the given ready pattern; optionally pulse done_i (y all 0x11)
    // in the cycle the byte with index inj_at is handshaken.
    task automatic collect(input int mode, input int nbytes, input int inj_at, input logic inj_clr);
        logic pstall;
        logic [7:0] pd;
        logic r;
        got_n = 0;
        stab_err = 0;
        pstall = 1'b0;
        pd = '0;
        for (int c = 0; c < 400 && got_n < nbytes; c++) begin
            if (pstall && (bus.tx_valid !== 1'b1 || bus.tx_data !== pd)) stab_err++;
            r = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            bus.tx_ready = r;
            done_i  = 1'b0;
            clear_i = 1'b0;
            if (bus.tx_valid && r) begin
                if (got_n == inj_at) begin
                    for (int i = 0; i < OUT_N; i++) y[i] = 8'h11;
                    done_i  = 1'b1;
                    clear_i = inj_clr;
                end
                got[got_n] = bus.tx_data;
                got_n++;
            end
            pstall = bus.tx_valid && !r;
            pd = bus.tx_data;
            @(posedge clk); #1;
        end
        done_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.tx_valid, busy, overrun, argmax_valid, argmax, bus.tx_data} !== '0)
            $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%b av=%b idx=%0d data=%h want all 0",
                     bus.tx_valid, busy, overrun, argmax_valid, argmax, bus.tx_data);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic early;
        int fb;
        early = 1'b0;
        start(V1);
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c < 10 && argmax_valid) early = 1'b1;
        end
        n_checks++;
        if (argmax_valid !== 1'b1 || early) $display("FAIL argmax_latency: valid=%b early=%b want valid at cycle 10", argmax_valid, early);
        else n_pass++;
        n_checks++;
        if (argmax !== 4'd2) $display("FAIL basic_argmax: got %0d want 2", argmax);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (argmax_valid !== 1'b0) $display("FAIL argmax_pulse: got %b want 0", argmax_valid);
        else n_pass++;
        exp_frame(V1, 8'h02);
        collect(0, NB, -1, 1'b0);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL basic_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
        n_checks++;
        if (got[12] !== 8'hA3) $display("FAIL basic_csum: got %h want a3", got[12]);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_drop: got %b want 0", busy);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0) $display("FAIL no_extra_bytes: valid=%b want 0", bus.tx_valid);
        else n_pass++;
    endtask

    task automatic test_tie_neg();
        int fb;
        start(VT);
        collect(0, NB, -1, 1'b0);
        exp_frame(VT, 8'h04);
        fb = first_bad();
        n_checks++;
        if (argmax !== 4'd4) $display("FAIL tie_argmax: got %0d want 4", argmax);
        else n_pass++;
        n_checks++;
        if (fb != -1) $display("FAIL tie_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
        start(VN);
        collect(0, NB, -1, 1'b0);
        exp_frame(VN, 8'h00);
        fb = first_bad();
        n_checks++;
        if (argmax !== 4'd0) $display("FAIL allneg_argmax: got %0d want 0", argmax);
        else n_pass++;
        n_checks++;
        if (fb != -1 || got[12] !== 8'hA5) $display("FAIL allneg_frame: byte %0d got %h want %h csum %h", fb, got[fb], expf[fb], got[12]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int fb;
        bus.tx_ready = 1'b0;
        start(V1);
        collect(1, NB, -1, 1'b0);
        exp_frame(V1, 8'h02);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL bp_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
        n_checks++;
        if (stab_err != 0) $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stab_err);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int fb;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_initial: got %b want 0", overrun);
        else n_pass++;
        start(V1);
        collect(0, NB, 3, 1'b0);
        exp_frame(V1, 8'h02);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL ovr_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun);
        else n_pass++;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun);
        else n_pass++;
        start(V1);
        collect(0, NB, 3, 1'b1);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_set_wins: got %b want 1", overrun);
        else n_pass++;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int fb;
        start(V1);
        collect(0, 5, -1, 1'b0);
        n_checks++;
        if (bus.tx_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midframe_pre: valid=%b busy=%b want 1 1", bus.tx_valid, busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || argmax !== 4'd0)
            $display("FAIL async_reset: valid=%b busy=%b idx=%0d want 0 0 0", bus.tx_valid, busy, argmax);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start(V1);
        collect(0, NB, -1, 1'b0);
        exp_frame(V1, 8'h02);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL post_reset_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
    endtask

    task automatic test_end_collision();
        int fb;
        start(V1);
        collect(0, NB, NB - 1, 1'b0);
        exp_frame(V1, 8'h02);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL coll_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL coll_overrun: got %b want 1", overrun);
        else n_pass++;
        load_y(VT);
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL coll_accept: busy=%b want 1", busy);
        else n_pass++;
        collect(0, NB, -1, 1'b0);
        exp_frame(VT, 8'h04);
        fb = first_bad();
        n_checks++;
        if (fb != -1) $display("FAIL coll_next_frame: byte %0d got %h want %h (n=%0d)", fb, got[fb], expf[fb], got_n);
        else n_pass++;
    endtask

    initial begin
        V1 = '{8'h03, 8'hFB, 8'h07, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h04, 8'h06, 8'h05};
        VT = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80};
        VN = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        bus.tx_ready = 1'b0;
        for (int i = 0; i < OUT_N; i++) y[i] = '0;
        test_reset();
        test_basic();
        test_tie_neg();
        test_backpressure();
        test_overrun();
        test_reset_midframe();
        test_end_collision();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inference_result_streamer.md
Name: inference_result_streamer

Overview:
Downstream consumer of the accelerator top. It snapshots the OUT_N signed result lanes when the top pulses done, computes the argmax class index over a sequential scan, and streams a framed byte packet to a host link (UART TX or debug FIFO) over a valid/ready handshake. It also exposes the argmax directly for on-chip use, and flags results dropped while a frame is still in flight.

Parameters:
DATA_WIDTH, 8, width of each signed result lane; must be 8 so each lane maps to one byte
OUT_N, 10, number of result lanes captured; range 2..255
SYNC_BYTE, 8'hA5, first byte of every frame
IDX_W, $clog2(OUT_N), width of the argmax index

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
done_i  input  1  one-cycle completion pulse from the accelerator top
y_i  input  OUT_N x DATA_WIDTH (signed, unpacked [0:OUT_N-1])  result lanes, valid in the done_i cycle
clear_i  input  1  synchronous clear of the sticky overrun flag
tx_data_o  output  8  frame byte
tx_valid_o  output  1  tx_data_o is valid
tx_ready_i  input  1  sink accepts the byte when tx_valid_o && tx_ready_i
argmax_o  output  IDX_W  index of the largest captured lane
argmax_valid_o  output  1  one-cycle pulse when argmax_o updates
busy_o  output  1  high in every state except S_IDLE
overrun_o  output  1  sticky: a done_i pulse was dropped

Behaviour:
- Reset values: every output 0; state S_IDLE; capture register, index and checksum cleared.
- S_IDLE:
  - On done_i, latch all y_i lanes into the capture register.
  - Set cur_max=cap[0], cur_idx=0, scan counter k=1.
  - Go to S_SCAN.
- S_SCAN: one lane per cycle.
  - If signed cap[k] > cur_max, update cur_max and cur_idx. A strict compare means ties keep the lowest index.
  - When k==OUT_N-1 and the compare is done, register argmax_o and pulse argmax_valid_o for one cycle, then go to S_HDR.
  - Latency from done_i to argmax_valid_o is OUT_N cycles.
- S_HDR:
  - Drive tx_data_o=SYNC_BYTE, tx_valid_o=1, checksum=SYNC_BYTE.
  - On handshake, go to S_DATA with byte counter j=0.
- S_DATA:
  - Drive tx_data_o=cap[j] (two's complement raw byte).
  - On handshake, checksum ^= cap[j] and j++.
  - After j==OUT_N-1, go to S_IDX.
- S_IDX:
  - Drive tx_data_o = zero-extended argmax.
  - On handshake, fold it into the checksum and go to S_CSUM.
- S_CSUM: drive the checksum; on handshake return to S_IDLE.
- Frame length: OUT_N+3 bytes.
- Handshake rules:
  - tx_valid_o is registered.
  - Once tx_valid_o is asserted, tx_data_o and tx_valid_o hold until tx_ready_i.
  - tx_valid_o never drops without a handshake (AXI-stream rule).
  - tx_ready_i may be high before valid. Back-to-back bytes then transfer every cycle, so the minimum frame time is OUT_N+3 cycles after S_SCAN.
- Boundary cases:
  - done_i while busy_o=1: the pulse is ignored, the capture register is untouched and overrun_o is set.
  - done_i in the same cycle the S_CSUM handshake completes: the FSM is still busy, so the pulse counts as an overrun. No bypass.
  - clear_i and a new overrun in the same cycle: set wins.
  - Asynchronous rst mid-frame aborts the frame immediately. tx_valid_o drops and no partial-frame recovery is attempted.
  - Lanes are opaque bytes; values -128 and 127 pass through unchanged.

Decomposition:
- Package tinyml_stream_pkg holds:
  - the state typedef (S_IDLE, S_SCAN, S_HDR, S_DATA, S_IDX, S_CSUM);
  - the SYNC_BYTE default;
  - a localparam FRAME_OVERHEAD=3.
- One natural sub-module, argmax_scanner: sequential signed max plus index over a captured array, with start/done. It is reusable for later softmax/top-k work.
- The framing FSM stays in the parent.

Test Plan:
1. Basic frame:
   - Stimulus: y = {3,-5,7,0,1,2,-1,4,6,5}, done_i pulse, tx_ready_i=1.
   - Response: argmax_valid_o exactly 10 cycles later with argmax_o=2.
   - Bytes A5,03,FB,07,00,01,02,FF,04,06,05,02, then checksum = XOR of all of those.
   - 13 bytes total; busy_o drops after the last byte.
2. Tie and negatives:
   - Stimulus: all lanes -128, except lanes 4 and 7 = 127.
   - Response: argmax_o=4.
   - Second run with all lanes -128: argmax_o=0.
3. Backpressure:
   - Stimulus: tx_ready_i toggles 1,0,0,1 repeating.
   - Response: tx_data_o/tx_valid_o are stable during every ready-low cycle.
   - Byte sequence is identical to scenario 1 with no duplicates or drops.
4. Overrun:
   - Stimulus: second done_i with y all 0x11 while in S_DATA.
   - Response: the frame still carries the first values and overrun_o=1.
   - clear_i then returns overrun_o to 0.
   - A simultaneous clear_i plus dropped done_i leaves overrun_o=1.
5. Reset mid-frame:
   - Stimulus: assert rst during S_DATA (j=4).
   - Response: tx_valid_o=0 and busy_o=0 asynchronously.
   - A new done_i after release produces a complete, correct frame from byte A5.
6. End-of-frame collision:
   - Stimulus: done_i in the cycle of the checksum handshake.
   - Response: the pulse is dropped and overrun_o=1.
   - A done_i one cycle later is accepted normally.
